// File: rtl/br_seq.sv
// Branch sequencer for the SISC fetch path: owns the PC, evaluates branch
// conditions, drives the branch adder and raises flush after a redirect.
// Optional BR_SEQ_STATS_EN adds saturating taken / not-taken counters.
module br_seq #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        br_req,
  input  logic        br_abs,
  input  logic        br_neg,
  input  logic [3:0]  br_cond,
  input  logic [3:0]  stat,
  input  logic [15:0] imm,
  input  logic        fetch_rdy,
  input  logic        stall,
  input  logic [15:0] br_addr,
  output logic [15:0] pc_out,
  output logic [15:0] pc_inc,
  output logic        br_sel,
  output logic [15:0] br_imm,
  output logic        fetch_req,
  output logic        br_taken,
  output logic        flush,
  output logic        busy
`ifdef BR_SEQ_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] nottaken_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_EVAL, ST_REDIRECT} state_e;

  // The flush counter runs down from FLUSH_CYCLES-1 to 0, one REDIRECT cycle each.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        br_sel_q, br_sel_d;
  logic [15:0] br_imm_q, br_imm_d;
  logic        neg_q, neg_d;
  logic [3:0]  cond_q, cond_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fetch_req_q, busy_q, flush_q, br_taken_q;
  logic        taken_pulse_d;
  logic        masked_any, cond_taken;

  assign masked_any = |(cond_q & stat);
  assign cond_taken = (cond_q == 4'd0) || (neg_q ? !masked_any : masked_any);

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    br_sel_d      = br_sel_q;
    br_imm_d      = br_imm_q;
    neg_d         = neg_q;
    cond_d        = cond_q;
    cnt_d         = cnt_q;
    taken_pulse_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (br_req) begin
          br_sel_d = br_abs;
          br_imm_d = imm;
          neg_d    = br_neg;
          cond_d   = br_cond;
          state_d  = ST_EVAL;
        end else if (fetch_rdy) begin
          pc_d = pc_q + 16'd1;
        end
      end
      ST_EVAL: begin
        if (cond_taken) begin
          pc_d          = br_addr;
          cnt_d         = FLUSH_LAST;
          taken_pulse_d = 1'b1;
          state_d       = ST_REDIRECT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (cnt_q == 3'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Stall freezes every register, including the registered outputs.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      br_sel_q    <= 1'b0;
      br_imm_q    <= 16'h0000;
      neg_q       <= 1'b0;
      cond_q      <= 4'h0;
      cnt_q       <= 3'd0;
      fetch_req_q <= 1'b0;
      busy_q      <= 1'b0;
      flush_q     <= 1'b0;
      br_taken_q  <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_sel_q    <= br_sel_d;
      br_imm_q    <= br_imm_d;
      neg_q       <= neg_d;
      cond_q      <= cond_d;
      cnt_q       <= cnt_d;
      fetch_req_q <= (state_d == ST_RUN);
      busy_q      <= (state_d != ST_RUN);
      flush_q     <= (state_d == ST_REDIRECT);
      br_taken_q  <= taken_pulse_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc_inc    = pc_q + 16'd1;
  assign br_sel    = br_sel_q;
  assign br_imm    = br_imm_q;
  assign fetch_req = fetch_req_q;
  assign busy      = busy_q;
  assign flush     = flush_q;
  // A pulse frozen by stall is held back and shows once the stall lifts.
  assign br_taken  = br_taken_q & ~stall;

`ifdef BR_SEQ_STATS_EN
  logic [15:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      taken_cnt_q    <= 16'h0000;
      nottaken_cnt_q <= 16'h0000;
    end else if (!stall && state_q == ST_EVAL) begin
      if (cond_taken) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (nottaken_cnt_q != 16'hFFFF) nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule
